// File: rtl/bcd_keypad_counter.sv
// Two-digit BCD up/down counter driven by debounced front-panel keys, with
// hold-to-repeat on the step keys and active-low seven-segment outputs.
module bcd_keypad_counter #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int RPT_DELAY  = 25_000_000,
  parameter int RPT_PERIOD = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [2:0] KEY,
  input  logic [7:0] SW,
  output logic [7:0] count_bcd,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic       load_err
);

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } step_state_t;

  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_key_acc;
  logic       r_load_acc_d;
  logic       r_load;
  logic [1:0] w_step;  // [0] down, [1] up
  logic       w_sw_valid;
  logic [7:0] w_inc;
  logic [7:0] w_dec;

  // Keys idle high, so the synchronizers reset to the released level.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the one before it.
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : gen_deb
    logic [DEB_W-1:0] r_cnt;
    logic             r_acc;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_cnt <= '0;
        r_acc <= 1'b1;
      end else if (r_sync2[g] == r_acc) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        r_acc <= r_sync2[g];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
    end

    assign w_key_acc[g] = r_acc;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_load_acc_d <= 1'b1;
      r_load       <= 1'b0;
    end else begin
      r_load_acc_d <= w_key_acc[0];
      r_load       <= r_load_acc_d & ~w_key_acc[0];
    end
  end

  // Step FSM g serves KEY[g+1]: g=0 is down, g=1 is up.
  for (genvar g = 0; g < 2; g++) begin : gen_step
    step_state_t      r_state;
    step_state_t      w_state_nxt;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_step;
    logic             w_step_nxt;
    logic             w_cnt_clr;
    logic             w_held;

    assign w_held = ~w_key_acc[g+1];

    always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      w_state_nxt = r_state;
      w_step_nxt  = 1'b0;
      w_cnt_clr   = 1'b0;
      case (r_state)
        ST_IDLE: begin
          w_cnt_clr = 1'b1;
          if (w_held) begin
            w_state_nxt = ST_HOLD;
            w_step_nxt  = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!w_held) begin
            w_state_nxt = ST_IDLE;
            w_cnt_clr   = 1'b1;
          end else if (r_rpt_cnt == RPT_W'(RPT_DELAY - 1)) begin
            w_state_nxt = ST_REPEAT;
            w_step_nxt  = 1'b1;
            w_cnt_clr   = 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!w_held) begin
            w_state_nxt = ST_IDLE;
            w_cnt_clr   = 1'b1;
          end else if (r_rpt_cnt == RPT_W'(RPT_PERIOD - 1)) begin
            w_step_nxt = 1'b1;
            w_cnt_clr  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_clr   = 1'b1;
        end
      endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_state   <= ST_IDLE;
        r_step    <= 1'b0;
        r_rpt_cnt <= '0;
      end else begin
        r_state   <= w_state_nxt;
        r_step    <= w_step_nxt;
        r_rpt_cnt <= w_cnt_clr ? '0 : r_rpt_cnt + RPT_W'(1);
      end
    end

    assign w_step[g] = r_step;
  end

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd0) begin
      r[3:0] = 4'd9;
      r[7:4] = (v[7:4] == 4'd0) ? 4'd9 : v[7:4] - 4'd1;
    end else begin
      r[3:0] = v[3:0] - 4'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign w_sw_valid = (SW[7:4] <= 4'd9) && (SW[3:0] <= 4'd9);
  assign w_inc      = bcd_inc(count_bcd);
  assign w_dec      = bcd_dec(count_bcd);

  // Load outranks steps; simultaneous up and down cancel out.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      count_bcd <= 8'h00;
      load_err  <= 1'b0;
    end else if (r_load) begin
      if (w_sw_valid) begin
        count_bcd <= SW;
        load_err  <= 1'b0;
      end else begin
        load_err  <= 1'b1;
      end
    end else if (w_step[1] && !w_step[0]) begin
      count_bcd <= w_inc;
    end else if (w_step[0] && !w_step[1]) begin
      count_bcd <= w_dec;
    end
  end

  assign HEX0 = seg7(count_bcd[3:0]);
  assign HEX1 = seg7(count_bcd[7:4]);

endmodule
